// File: rtl/acl2_sample_sequencer.sv
// Bus master that drives the SPI register block to burst-read one X/Y/Z sample
// (command 0x0B, address 0x0E, six data bytes) from the PmodACL2.
module acl2_sample_sequencer #(
  parameter logic [7:0]  BASE_ADDRESS = 8'h00,
  parameter logic [7:0]  SPCR_INIT    = 8'h50,
  parameter logic [7:0]  SPER_INIT    = 8'h00,
  parameter logic [15:0] POLL_LIMIT   = 16'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] sample_x,
  output logic [15:0] sample_y,
  output logic [15:0] sample_z,
  output logic [7:0]  port_id,
  output logic [7:0]  bus_dout,
  output logic        write_strobe,
  output logic        read_strobe,
  input  logic [7:0]  bus_din
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_SPCR, S_CFG_SPER, S_CS_LOW, S_WR_BYTE, S_POLL_RD,
    S_POLL_CHK, S_DATA_RD, S_NEXT, S_CS_HIGH, S_DONE, S_ABORT
  } state_t;

  state_t      r_state;
  logic [1:0]  r_ph;
  logic [2:0]  r_idx;
  logic [15:0] r_poll;
  logic        r_cfg_done;
  logic        r_busy, r_done, r_error, r_ws, r_rs;
  logic [7:0]  r_port, r_dout;
  logic [15:0] r_sx, r_sy, r_sz;
  logic [7:0]  r_buf [0:5];

  logic [7:0]  w_tx;
  logic [7:0]  w_addr;
  logic [7:0]  w_data;
  state_t      w_wr_next;
  logic        w_last_poll;
  logic        w_buf_we;

  assign w_tx        = (r_idx == 3'd0) ? 8'h0B : (r_idx == 3'd1) ? 8'h0E : 8'h00;
  assign w_last_poll = (r_poll == POLL_LIMIT - 16'd1);
  assign w_buf_we    = (r_state == S_DATA_RD) && (r_ph == 2'd2) && (r_idx >= 3'd2);

  always_comb begin
    w_addr    = BASE_ADDRESS;
    w_data    = 8'h00;
    w_wr_next = S_IDLE;
    case (r_state)
      S_CFG_SPCR: begin w_addr = BASE_ADDRESS;         w_data = SPCR_INIT; w_wr_next = S_CFG_SPER; end
      S_CFG_SPER: begin w_addr = BASE_ADDRESS + 8'd3;  w_data = SPER_INIT; w_wr_next = S_CS_LOW;   end
      S_CS_LOW:   begin w_addr = BASE_ADDRESS + 8'd4;  w_data = 8'h00;     w_wr_next = S_WR_BYTE;  end
      S_WR_BYTE:  begin w_addr = BASE_ADDRESS + 8'd2;  w_data = w_tx;      w_wr_next = S_POLL_RD;  end
      S_POLL_RD:  w_addr = BASE_ADDRESS + 8'd1;
      S_DATA_RD:  w_addr = BASE_ADDRESS + 8'd2;
      S_CS_HIGH:  begin w_addr = BASE_ADDRESS + 8'd4;  w_data = 8'h01;     w_wr_next = S_DONE;     end
      S_ABORT:    begin w_addr = BASE_ADDRESS + 8'd4;  w_data = 8'h01;     w_wr_next = S_IDLE;     end
      default:    ;
    endcase
  end

  // Every bus operation spans at least two cycles, so strobes can never be back to back.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ph       <= 2'd0;
      r_idx      <= 3'd0;
      r_poll     <= 16'd0;
      r_cfg_done <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_ws       <= 1'b0;
      r_rs       <= 1'b0;
      r_port     <= 8'h00;
      r_dout     <= 8'h00;
      r_sx       <= 16'h0000;
      r_sy       <= 16'h0000;
      r_sz       <= 16'h0000;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_ws    <= 1'b0;
      r_rs    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // r_done/r_error are visible this cycle: a start coinciding with them is dropped
          if (start && !r_done && !r_error) begin
            r_busy  <= 1'b1;
            r_ph    <= 2'd0;
            r_state <= r_cfg_done ? S_CS_LOW : S_CFG_SPCR;
          end
        end
        S_CFG_SPCR, S_CFG_SPER, S_CS_LOW, S_WR_BYTE, S_CS_HIGH, S_ABORT: begin
          if (r_ph == 2'd0) begin
            r_port <= w_addr;
            r_dout <= w_data;
            r_ws   <= 1'b1;
            r_ph   <= 2'd1;
            if (r_state == S_CS_HIGH) begin
              r_sx <= {r_buf[1], r_buf[0]};
              r_sy <= {r_buf[3], r_buf[2]};
              r_sz <= {r_buf[5], r_buf[4]};
            end
          end else begin
            r_ph    <= 2'd0;
            r_state <= w_wr_next;
            if (r_state == S_CFG_SPER) r_cfg_done <= 1'b1;
            if (r_state == S_CS_LOW)   r_idx      <= 3'd0;
            if (r_state == S_WR_BYTE)  r_poll     <= 16'd0;
            if (r_state == S_ABORT) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        S_POLL_RD: begin
          if (r_ph == 2'd0) begin
            r_port <= w_addr;
            r_rs   <= 1'b1;
            r_ph   <= 2'd1;
          end else begin
            r_ph    <= 2'd0;
            r_state <= S_POLL_CHK;
          end
        end
        S_POLL_CHK: begin
          if (!bus_din[0]) begin
            r_state <= S_DATA_RD;
          end else if (w_last_poll) begin
            r_state <= S_ABORT;
          end else begin
            r_poll  <= r_poll + 16'd1;
            r_state <= S_POLL_RD;
          end
        end
        S_DATA_RD: begin
          if (r_ph == 2'd0) begin
            r_port <= w_addr;
            r_rs   <= 1'b1;
            r_ph   <= 2'd1;
          end else if (r_ph == 2'd1) begin
            r_ph <= 2'd2;
          end else begin
            r_ph    <= 2'd0;
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_idx == 3'd7) begin
            r_state <= S_CS_HIGH;
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_state <= S_WR_BYTE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bytes 2..7 land in XL, XH, YL, YH, ZL, ZH order
  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[r_idx - 3'd2] <= bus_din;
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign sample_x     = r_sx;
  assign sample_y     = r_sy;
  assign sample_z     = r_sz;
  assign port_id      = r_port;
  assign bus_dout     = r_dout;
  assign write_strobe = r_ws;
  assign read_strobe  = r_rs;

endmodule

// File: tb/tb_acl2_sample_sequencer.sv
// Directed bench: SPI register block model on the port bus, op-log comparison,
// sample checks, poll timeout, busy/reset behaviour and bus protocol monitor.
module tb_acl2_sample_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bus_din = 8'h00;
  logic        busy, done, error, write_strobe, read_strobe;
  logic [15:0] sample_x, sample_y, sample_z;
  logic [7:0]  port_id, bus_dout;

  acl2_sample_sequencer #(.POLL_LIMIT(16'd8)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
    .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .port_id(port_id), .bus_dout(bus_dout), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .bus_din(bus_din)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int viol = 0;
  int busy_gap = 0;
  logic [7:0]  rx [8];
  int busy_n = 0;
  int poll_cnt = 0;
  int rx_idx = 0;
  logic [19:0] ops [$];
  logic [19:0] exp_ops [$];
  logic        prev_rs = 1'b0;
  logic        prev_ws = 1'b0;
  logic [7:0]  prev_port = 8'h00;

  // Slave model, op logger and protocol monitor
  always @(posedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (error) err_cnt++;
      if ((read_strobe || write_strobe) && (prev_rs || prev_ws)) viol++;
      if (read_strobe && write_strobe) viol++;
      if (prev_rs && port_id != prev_port) viol++;
      if (write_strobe) begin
        ops.push_back({4'h1, port_id, bus_dout});
        if (port_id == 8'h02) poll_cnt = 0;
        if (port_id == 8'h04 && bus_dout == 8'h00) rx_idx = 0;
      end
      if (read_strobe) begin
        ops.push_back({4'h2, port_id, 8'h00});
        if (port_id == 8'h01) begin
          if (poll_cnt < busy_n) begin
            bus_din <= 8'h01;
            poll_cnt++;
          end else begin
            bus_din <= 8'h00;
          end
        end else if (port_id == 8'h02) begin
          bus_din <= rx[rx_idx];
          rx_idx = (rx_idx + 1) % 8;
        end
      end
    end
    prev_rs   = read_strobe;
    prev_ws   = write_strobe;
    prev_port = port_id;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic exp_burst(input bit cfg, input int polls);
    exp_ops.delete();
    if (cfg) begin
      exp_ops.push_back({4'h1, 8'h00, 8'h50});
      exp_ops.push_back({4'h1, 8'h03, 8'h00});
    end
    exp_ops.push_back({4'h1, 8'h04, 8'h00});
    for (int b = 0; b < 8; b++) begin
      exp_ops.push_back({4'h1, 8'h02, (b == 0) ? 8'h0B : (b == 1) ? 8'h0E : 8'h00});
      for (int p = 0; p < polls; p++) exp_ops.push_back({4'h2, 8'h01, 8'h00});
      exp_ops.push_back({4'h2, 8'h02, 8'h00});
    end
    exp_ops.push_back({4'h1, 8'h04, 8'h01});
  endtask

  task automatic cmp_ops(input string tag);
    check({tag, "_len"}, ops.size(), exp_ops.size());
    for (int i = 0; i < exp_ops.size() && i < ops.size(); i++) check(tag, ops[i], exp_ops[i]);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Wait for done/error; busy must stay high until then
  task automatic wait_evt(input int budget);
    int n;
    n = 0;
    busy_gap = 0;
    while (!(done || error) && n < budget) begin
      if (!busy) busy_gap++;
      @(negedge clk);
      n++;
    end
    check("timeout", n < budget, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_ws"}, write_strobe, 0);
    check({tag, "_rs"}, read_strobe, 0);
    check({tag, "_port"}, port_id, 0);
    check({tag, "_dout"}, bus_dout, 0);
    check({tag, "_sx"}, sample_x, 0);
    check({tag, "_sy"}, sample_y, 0);
    check({tag, "_sz"}, sample_z, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_zero("rst");

    // 1: first burst configures the core
    rx = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    busy_n = 0;
    ops.delete();
    exp_burst(1'b1, 1);
    pulse_start();
    wait_evt(1000);
    repeat (5) @(negedge clk);
    cmp_ops("s1_ops");
    check("s1_done_cnt", done_cnt, 1);
    check("s1_sx", sample_x, 16'h2211);
    check("s1_sy", sample_y, 16'h4433);
    check("s1_sz", sample_z, 16'h6655);
    $display("s1 first burst: x=%h y=%h z=%h", sample_x, sample_y, sample_z);

    // 2: no reconfiguration; start coinciding with done is ignored
    rx = '{8'h00, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h80};
    ops.delete();
    exp_burst(1'b0, 1);
    pulse_start();
    wait_evt(1000);
    check("s2_done_vis", done, 1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    check("s2_start_on_done_busy", busy, 0);
    cmp_ops("s2_ops");
    check("s2_done_cnt", done_cnt, 2);
    check("s2_sx", sample_x, 16'h1234);
    check("s2_sy", sample_y, 16'hABCD);
    check("s2_sz", sample_z, 16'h8001);
    $display("s2 second burst: x=%h y=%h z=%h", sample_x, sample_y, sample_z);

    // 3: three busy polls per byte
    rx = '{8'h00, 8'h00, 8'h78, 8'h56, 8'hEF, 8'hBE, 8'h02, 8'h40};
    busy_n = 3;
    ops.delete();
    exp_burst(1'b0, 4);
    pulse_start();
    wait_evt(2000);
    check("s3_busy_gap", busy_gap, 0);
    repeat (5) @(negedge clk);
    cmp_ops("s3_ops");
    check("s3_sx", sample_x, 16'h5678);
    check("s3_sy", sample_y, 16'hBEEF);
    check("s3_sz", sample_z, 16'h4002);
    $display("s3 polled burst: x=%h y=%h z=%h", sample_x, sample_y, sample_z);

    // 4: SPSR stuck, timeout after 8 polls
    busy_n = 1000000;
    ops.delete();
    exp_ops.delete();
    exp_ops.push_back({4'h1, 8'h04, 8'h00});
    exp_ops.push_back({4'h1, 8'h02, 8'h0B});
    for (int p = 0; p < 8; p++) exp_ops.push_back({4'h2, 8'h01, 8'h00});
    exp_ops.push_back({4'h1, 8'h04, 8'h01});
    pulse_start();
    wait_evt(1000);
    check("s4_err_vis", error, 1);
    check("s4_busy", busy, 0);
    repeat (5) @(negedge clk);
    cmp_ops("s4_ops");
    check("s4_err_cnt", err_cnt, 1);
    check("s4_done_cnt", done_cnt, 3);
    check("s4_sx", sample_x, 16'h5678);
    check("s4_sy", sample_y, 16'hBEEF);
    check("s4_sz", sample_z, 16'h4002);
    $display("s4 timeout: err_cnt=%0d ops=%0d", err_cnt, ops.size());

    // 5a: extra start while busy is ignored
    busy_n = 0;
    rx = '{8'h00, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h80};
    ops.delete();
    exp_burst(1'b0, 1);
    pulse_start();
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_evt(1000);
    repeat (30) @(negedge clk);
    check("s5_busy_idle", busy, 0);
    cmp_ops("s5a_ops");
    check("s5_done_cnt", done_cnt, 4);
    $display("s5a extra start: ops=%0d done_cnt=%0d", ops.size(), done_cnt);

    // 5b: reset mid-burst, then reconfiguration on the next start
    pulse_start();
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check_zero("s5_rst");
    ops.delete();
    exp_burst(1'b1, 1);
    pulse_start();
    wait_evt(1000);
    repeat (5) @(negedge clk);
    cmp_ops("s5b_ops");
    check("s5b_sx", sample_x, 16'h1234);
    check("s5b_sz", sample_z, 16'h8001);
    $display("s5b after reset: x=%h z=%h", sample_x, sample_z);

    // 6: protocol monitor over the whole run
    check("protocol_viol", viol, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
